axi4_slave_mem: RTL

//  AXI4 responder: memory-backed slave answering a master on the AXI4 channel set
//  (AW/W/B/AR/R; 4-bit LEN, 9-bit IDs, WID present). It is the DUT-side counterpart
//  of the master driver. Write and read paths are independent FSMs sharing one word array.

---
 rtl/axi4_slave_mem_pkg.sv | 29 ++
 rtl/axi4_slave_mem_if.sv | 69 ++++++
 rtl/axi4_slave_mem_burst_addr.sv | 48 ++++
 rtl/axi4_slave_mem.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_slave_mem_pkg.sv
// Shared AXI4 definitions for the memory-backed slave: bus widths, burst
// encodings, response codes and the write/read FSM state types.
package axi_parameters;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;

  // Encoding 2'b11 is reserved on the bus and is handled like INCR.
  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rstate_t;

endpackage

// File: rtl/axi4_slave_mem_if.sv
// AXI4 channel bundle (AW/W/B/AR/R, 4-bit LEN, WID present) with master and
// slave views.
interface axi4_slave_mem_if #(
  parameter int ID_WIDTH   = 9,
  parameter int ADDR_WIDTH = axi_parameters::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_parameters::DATA_WIDTH
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [3:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [ID_WIDTH-1:0]     WID;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [3:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WID, WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WID, WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

endinterface

// File: rtl/axi4_slave_mem_burst_addr.sv
// Combinational AXI4 next-beat address: FIXED holds, INCR/reserved step by
// the (bus-clamped) transfer size, WRAP steps and folds back inside a
// (len+1)*bytes window. WRAP with an illegal length behaves as INCR.
module axi4_burst_addr
  import axi_parameters::*;
#(
  parameter int ADDR_WIDTH = axi_parameters::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_parameters::DATA_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [3:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] next_addr_o
);
  localparam int         LOG2B    = $clog2(DATA_WIDTH/8);
  localparam logic [2:0] MAX_SIZE = 3'(LOG2B);

  logic [2:0]            eff_size;
  logic [2:0]            wrap_sh;
  logic                  wrap_ok;
  logic [ADDR_WIDTH-1:0] bytes, aligned, incr, span, base;

  // Size is clamped to the bus width; the wrap window is bytes << log2(len+1).
  always_comb begin
    eff_size = (size_i > MAX_SIZE) ? MAX_SIZE : size_i;
    bytes    = ADDR_WIDTH'(1) << eff_size;
    aligned  = addr_i & ~(bytes - ADDR_WIDTH'(1));
    incr     = aligned + bytes;
    wrap_ok  = 1'b1;
    wrap_sh  = 3'd0;
    case (len_i)
      4'd1:    wrap_sh = 3'd1;
      4'd3:    wrap_sh = 3'd2;
      4'd7:    wrap_sh = 3'd3;
      4'd15:   wrap_sh = 3'd4;
      default: wrap_ok = 1'b0;
    endcase
    span = bytes << wrap_sh;
    base = aligned & ~(span - ADDR_WIDTH'(1));
    case (burst_i)
      BURST_FIXED: next_addr_o = addr_i;
      BURST_WRAP:  next_addr_o = (wrap_ok && (incr == base + span)) ? base : incr;
      default:     next_addr_o = incr;
    endcase
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 memory-backed slave. Independent write (AW/W/B) and read (AR/R) FSMs
// share one word array; one outstanding burst per direction.
// Optional macro AXI_SLAVE_ERR_RESP_EN: out-of-range word indices return
// SLVERR (writes dropped, read data zero) instead of wrapping silently.
module axi4_slave_mem
  import axi_parameters::*;
#(
  parameter int ADDR_WIDTH = axi_parameters::ADDR_WIDTH,
  parameter int DATA_WIDTH = axi_parameters::DATA_WIDTH,
  parameter int ID_WIDTH   = 9,
  parameter int MEM_DEPTH  = 1024
) (
  input logic           clk,
  input logic           rst,
  axi4_slave_mem_if.slave bus
);
  localparam int STRB_W = DATA_WIDTH/8;
  localparam int LOG2B  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // ---------------- write path state ----------------
  wstate_t               w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   awid_q, awid_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d, w_next;
  logic [3:0]            awlen_q, awlen_d, wbeat_q, wbeat_d;
  logic [2:0]            awsize_q, awsize_d;
  logic [1:0]            awburst_q, awburst_d;
  logic                  werr_q, werr_d;
  logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic                  mem_we, w_err;
  logic [IDX_W-1:0]      w_idx;

  // ---------------- read path state ----------------
  rstate_t               r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   rid_q, rid_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d, r_next, rd_addr;
  logic [3:0]            arlen_q, arlen_d, rbeat_q, rbeat_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, rd_word;
  logic                  rlast_q, rlast_d, arready_q, arready_d, rvalid_q, rvalid_d;
  logic                  r_err;
  logic [IDX_W-1:0]      r_idx;

  // WID/WLAST carry no information for this slave; rd_addr bits outside
  // the word index only matter for the range check.
  logic unused_ok;
  assign unused_ok = ^{bus.WID, bus.WLAST, rd_addr};

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_waddr (
    .addr_i(waddr_q), .len_i(awlen_q), .size_i(awsize_q), .burst_i(awburst_q),
    .next_addr_o(w_next)
  );

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_raddr (
    .addr_i(raddr_q), .len_i(arlen_q), .size_i(arsize_q), .burst_i(arburst_q),
    .next_addr_o(r_next)
  );

  // In R_IDLE the word being loaded is the one the AR channel presents;
  // during a burst it is the next beat's address.
  assign rd_addr = (r_state_q == R_IDLE) ? bus.ARADDR : r_next;
  assign w_idx   = waddr_q[LOG2B +: IDX_W];
  assign r_idx   = rd_addr[LOG2B +: IDX_W];

`ifdef AXI_SLAVE_ERR_RESP_EN
  assign w_err = (waddr_q >> LOG2B) >= ADDR_WIDTH'(MEM_DEPTH);
  assign r_err = (rd_addr >> LOG2B) >= ADDR_WIDTH'(MEM_DEPTH);
`else
  assign w_err = 1'b0;
  assign r_err = 1'b0;
`endif

  assign rd_word = r_err ? '0 : mem[r_idx];

  // Write FSM next state; handshake outputs are registered from the next state.
  always_comb begin
    w_state_d = w_state_q;
    awid_d    = awid_q;
    waddr_d   = waddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    awburst_d = awburst_q;
    wbeat_d   = wbeat_q;
    werr_d    = werr_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (bus.AWVALID && awready_q) begin
          awid_d    = bus.AWID;
          waddr_d   = bus.AWADDR;
          awlen_d   = bus.AWLEN;
          awsize_d  = bus.AWSIZE;
          awburst_d = bus.AWBURST;
          wbeat_d   = '0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // Burst length comes from AWLEN alone; WLAST is not consulted.
        if (bus.WVALID && wready_q) begin
          mem_we  = !w_err;
          werr_d  = werr_q | w_err;
          waddr_d = w_next;
          wbeat_d = wbeat_q + 4'd1;
          if (wbeat_q == awlen_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bus.BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write FSM registers; reset clears every bus-visible output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state_q <= W_IDLE;
      awid_q    <= '0;
      waddr_q   <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
      awburst_q <= '0;
      wbeat_q   <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      awid_q    <= awid_d;
      waddr_q   <= waddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      awburst_q <= awburst_d;
      wbeat_q   <= wbeat_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
    end
  end

  // Byte-masked memory write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.WSTRB[b]) mem[w_idx][8*b +: 8] <= bus.WDATA[8*b +: 8];
      end
    end
  end

  // Read FSM next state; RDATA is loaded on AR accept and on each accepted beat.
  always_comb begin
    r_state_d = r_state_q;
    rid_d     = rid_q;
    raddr_d   = raddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rbeat_d   = rbeat_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      R_IDLE: begin
        if (bus.ARVALID && arready_q) begin
          rid_d     = bus.ARID;
          raddr_d   = bus.ARADDR;
          arlen_d   = bus.ARLEN;
          arsize_d  = bus.ARSIZE;
          arburst_d = bus.ARBURST;
          rbeat_d   = '0;
          rlast_d   = (bus.ARLEN == 4'd0);
          rdata_d   = rd_word;
          rresp_d   = r_err ? RESP_SLVERR : RESP_OKAY;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.RREADY) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            raddr_d = r_next;
            rbeat_d = rbeat_q + 4'd1;
            rlast_d = ((rbeat_q + 4'd1) == arlen_q);
            rdata_d = rd_word;
            rresp_d = r_err ? RESP_SLVERR : RESP_OKAY;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read FSM registers; reset clears every bus-visible output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      rid_q     <= '0;
      raddr_q   <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rbeat_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      rlast_q   <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rbeat_q   <= rbeat_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
    end
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BID     = awid_q;
  assign bus.BRESP   = werr_q ? RESP_SLVERR : RESP_OKAY;
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RID     = rid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RLAST   = rlast_q;

endmodule
